truth_table_sweeper: RTL and testbench
======================================

// Module: truth_table_sweeper
// PURPOSE
//  Controller that characterises one 3-input combinational logic gate, such as the
//  single-output truth-table gate modules in our 3-input gate library.
//  On start it drives all 8 input vectors in order and waits a programmable settle time
//  after each, then samples the gate output.
//  It builds the observed 8-bit truth table, compares it against an expected table, and
//  reports per-row mismatches and pass/fail.
//  Sits between the test/config host and one gate instance; owns the gate's in1..in3.
// PARAMETERS
//  SETTLE_CYCLES  4   cycles a vector is held before sampling; legal range 1..255
//  CNT_W          8   settle counter width; must satisfy SETTLE_CYCLES < 2**CNT_W
// PORTS
//  clk         in   1  single clock; every register is clocked on its rising edge
//  reset       in   1  asynchronous, active-high reset
//  start       in   1  one-cycle request to begin a sweep; accepted only in IDLE
//  abort       in   1  terminates a running sweep; takes priority over all but reset
//  expected    in   8  expected truth table; latched on start accept
//  gate_out    in   1  output of the gate under control
//  in1,in2,in3 out  1  gate inputs; vector idx = {in1,in2,in3}
//  busy        out  1  high from the cycle after start accept until done/abort
//  done        out  1  one-cycle pulse at the end of a sweep (normal or aborted)
//  aborted     out  1  qualifies done; high when the sweep ended by abort
//  pass        out  1  observed == expected latched at completion; 0 when aborted
//  observed    out  8  observed truth table
//  mismatch    out  8  observed ^ expected; valid with done
// BEHAVIOUR
//  - Table bit convention: vector idx maps to bit [7-idx], so input 000 is the MSB.
//    Example: expected 8'h95 means row 000=1, row 001=0, ..., row 111=1.
//  - Reset (async): state=IDLE, idx=0, in1..in3=0, busy=0, done=0, aborted=0, pass=0,
//    observed=0, mismatch=0, settle count=0.
//  - FSM states: IDLE, SETTLE, SAMPLE, DONE.
//  - IDLE: start=1 at cycle t0 -> latch expected, clear observed/mismatch/pass/aborted,
//    set idx=0 -> SETTLE at t0+1 with in=000 and busy=1.
//  - SETTLE: vector held and counter increments each cycle.
//    After SETTLE_CYCLES cycles in SETTLE -> SAMPLE.
//  - SAMPLE (1 cycle): observed[7-idx] <= gate_out.
//    If idx==7 -> DONE; else idx+1, counter=0 -> SETTLE.
//  - Each vector occupies SETTLE_CYCLES+1 cycles.
//    Vector k is sampled at t0+1+k*(SETTLE_CYCLES+1)+SETTLE_CYCLES.
//  - DONE (1 cycle): done=1, busy=0, pass=(observed==expected), mismatch=observed^expected.
//    Done is registered at t0+8*(SETTLE_CYCLES+1)+1. Next state IDLE; in1..in3 return to 000.
//  - start while busy or in DONE: ignored; expected is not re-latched.
//  - abort in SETTLE/SAMPLE: the next cycle is DONE with aborted=1 and pass=0.
//    Observed keeps the rows sampled so far; mismatch = observed^expected.
//    If abort coincides with the SAMPLE of a row, the abort wins and that row is not stored.
//  - abort in IDLE: no effect. start and abort together in IDLE: start wins.
//  - start in the cycle after DONE (IDLE) is accepted: sweeps can run back-to-back.
//  - Reset asserted mid-sweep: immediate return to reset values; no done pulse.
//  - gate_out is sampled as a synchronous input in the clk domain; no synchroniser is
//    added here.
//  - observed/mismatch/pass hold their values until the next start accept.
// STRUCTURE
//  - Package truth_table_pkg:
//    - state enum (IDLE, SETTLE, SAMPLE, DONE)
//    - VEC_W=3, TT_W=8, NUM_ROWS=8
//    - function row_bit(idx) = TT_W-1-idx
//  - Sub-module settle_timer (CNT_W, SETTLE_CYCLES):
//    - inputs: clear, enable
//    - output: expired, high while count == SETTLE_CYCLES
//  - Top level holds the FSM, the idx counter and the result registers.
// TESTING
//  1. Gate model = 8'h95, expected=8'h95, SETTLE_CYCLES=4 -> done at t0+41,
//     observed=8'h95, mismatch=8'h00, pass=1, aborted=0.
//  2. Same model, expected=8'h96 -> observed=8'h95, mismatch=8'h03, pass=0.
//  3. Drive-order check: monitor in1..in3 -> exactly 000,001,...,111, each held 5 cycles;
//     the sample of row k lands on cycle t0+5+5k.
//  4. Abort asserted on the sample cycle of row 2 -> done next cycle with aborted=1 and
//     pass=0. Observed holds only bits 7,6 (8'h80 for model 0x95); in returns to 000.
//  5. start pulsed again at t0+10 (busy) -> ignored. Sweep length and expected unchanged;
//     a start in the IDLE cycle after done begins a new sweep.
//  6. reset asserted at t0+17 asynchronously, mid-cycle -> all outputs zero before the next
//     clock edge, state IDLE, no done pulse. A fresh sweep afterwards gives the case-1 results.

Source files
------------

// File: rtl/truth_table_pkg.sv
// Shared types and constants for the 3-input gate truth-table sweeper.
// A truth table stores row idx at bit [TT_W-1-idx], so input vector 000 is the MSB.
package truth_table_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    localparam int VEC_W    = 3;
    localparam int TT_W     = 8;
    localparam int NUM_ROWS = 8;

    function automatic logic [VEC_W-1:0] row_bit(input logic [VEC_W-1:0] idx);
        return VEC_W'(TT_W - 1) - idx;
    endfunction

endpackage

// File: rtl/truth_table_sweeper_settle_timer.sv
// Settle timer: counts cycles while enabled. expiring flags the last settle cycle
// so the controller can move to SAMPLE on time; expired stays high once the count is reached.
module settle_timer #(
    parameter int CNT_W         = 8,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expiring,
    output logic expired
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired  = (count_q == CNT_W'(SETTLE_CYCLES));
    assign expiring = enable && !clear && (count_q == CNT_W'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps all 8 input vectors of one 3-input gate, samples its output after a settle
// time, and reports the observed table, per-row mismatches and pass/fail.
module truth_table_sweeper
    import truth_table_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            abort,
    input  logic [TT_W-1:0] expected,
    input  logic            gate_out,
    output logic            in1,
    output logic            in2,
    output logic            in3,
    output logic            busy,
    output logic            done,
    output logic            aborted,
    output logic            pass,
    output logic [TT_W-1:0] observed,
    output logic [TT_W-1:0] mismatch
);

    state_t           state_q, state_d;
    logic [VEC_W-1:0] idx_q, idx_d;
    logic [TT_W-1:0]  exp_q, exp_d;
    logic [TT_W-1:0]  observed_q, observed_d;
    logic [TT_W-1:0]  mismatch_q, mismatch_d;
    logic             pass_q, pass_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;

    logic timer_clear;
    logic timer_expiring;
    logic timer_expired;
    logic finish;

    settle_timer #(
        .CNT_W         (CNT_W),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (timer_clear),
        .enable   (state_q == SETTLE),
        .expiring (timer_expiring),
        .expired  (timer_expired)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        exp_d       = exp_q;
        observed_d  = observed_q;
        mismatch_d  = mismatch_q;
        pass_d      = pass_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        aborted_d   = aborted_q;
        timer_clear = 1'b0;
        finish      = 1'b0;

        case (state_q)
            IDLE: begin
                // start beats a simultaneous abort here
                if (start) begin
                    exp_d       = expected;
                    observed_d  = '0;
                    mismatch_d  = '0;
                    pass_d      = 1'b0;
                    aborted_d   = 1'b0;
                    idx_d       = '0;
                    busy_d      = 1'b1;
                    timer_clear = 1'b1;
                    state_d     = SETTLE;
                end
            end
            SETTLE: begin
                if (abort) begin
                    finish = 1'b1;
                end else if (timer_expiring) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                // An abort on the sample cycle discards this row
                if (abort) begin
                    finish = 1'b1;
                end else begin
                    if (timer_expired) begin
                        observed_d[row_bit(idx_q)] = gate_out;
                    end
                    if (idx_q == VEC_W'(NUM_ROWS - 1)) begin
                        finish = 1'b1;
                    end else begin
                        idx_d       = idx_q + 1'b1;
                        timer_clear = 1'b1;
                        state_d     = SETTLE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (finish) begin
            state_d     = DONE;
            done_d      = 1'b1;
            busy_d      = 1'b0;
            idx_d       = '0;
            aborted_d   = abort;
            mismatch_d  = observed_d ^ exp_q;
            pass_d      = !abort && (observed_d == exp_q);
            timer_clear = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            exp_q      <= '0;
            observed_q <= '0;
            mismatch_q <= '0;
            pass_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            exp_q      <= exp_d;
            observed_q <= observed_d;
            mismatch_q <= mismatch_d;
            pass_q     <= pass_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            aborted_q  <= aborted_d;
        end
    end

    assign {in1, in2, in3} = idx_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign aborted         = aborted_q;
    assign pass            = pass_q;
    assign observed        = observed_q;
    assign mismatch        = mismatch_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: a table-driven gate model answers the DUT's vectors,
// and each sweep's timing and results are predicted from the sweep rules directly.
module tb_truth_table_sweeper;

    localparam int S = 4;
    localparam int P = S + 1;

    logic       clk;
    logic       reset;
    logic       start;
    logic       abort;
    logic [7:0] expected;
    logic       gate_out;
    logic       in1, in2, in3;
    logic       busy, done, aborted, pass;
    logic [7:0] observed, mismatch;

    logic [7:0] model_tt;
    int total = 0;
    int bad   = 0;

    truth_table_sweeper #(
        .SETTLE_CYCLES (S),
        .CNT_W         (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .expected (expected),
        .gate_out (gate_out),
        .in1      (in1),
        .in2      (in2),
        .in3      (in3),
        .busy     (busy),
        .done     (done),
        .aborted  (aborted),
        .pass     (pass),
        .observed (observed),
        .mismatch (mismatch)
    );

    // Behavioural gate: row {in1,in2,in3} lives at bit 7-row of the model table
    assign gate_out = model_tt[3'd7 - {in1, in2, in3}];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Called at a negedge in IDLE. abort_row<0: no abort; rst_at<0: no reset.
    task automatic run_sweep(input logic [7:0] mdl, input logic [7:0] exp_tt,
                             input int abort_row, input bit restart,
                             input bit abort_with_start, input int rst_at);
        int n, done_n, want_n, rows, bad_vec, bad_busy;
        bit got_done;
        logic [7:0] want_obs;
        model_tt = mdl;
        start    = 1'b1;
        abort    = abort_with_start;
        expected = exp_tt;
        @(negedge clk);
        start    = 1'b0;
        abort    = 1'b0;
        expected = ~exp_tt;
        n = 1; got_done = 1'b0; done_n = 0; bad_vec = 0; bad_busy = 0;
        while (!got_done && n <= 8 * P + 10) begin
            if (done) begin
                got_done = 1'b1;
                done_n   = n;
            end else begin
                if ({in1, in2, in3} != 3'((n - 1) / P)) bad_vec++;
                if (!busy) bad_busy++;
                if (rst_at >= 0 && n == rst_at) begin
                    #2 reset = 1'b1;
                    #1;
                    check_eq("rst_async_outs",
                             {in1, in2, in3, busy, done, aborted, pass, observed, mismatch}, '0);
                    for (int i = 0; i < 3; i++) begin
                        @(negedge clk);
                        check_eq("rst_no_done", {done, busy}, 2'b00);
                    end
                    reset = 1'b0;
                    $display("sweep model=%02h exp=%02h reset at t0+%0d", mdl, exp_tt, rst_at);
                    return;
                end
                abort = (abort_row >= 0) && (n == abort_row * P + P);
                start = restart && (n == 10);
                expected = start ? ~exp_tt : expected;
                @(negedge clk);
                n++;
            end
        end
        abort = 1'b0;
        start = 1'b0;
        rows   = (abort_row >= 0) ? abort_row : 8;
        want_n = (abort_row >= 0) ? abort_row * P + P + 1 : 8 * P + 1;
        want_obs = '0;
        for (int i = 0; i < rows; i++) want_obs[7 - i] = mdl[7 - i];
        check_eq("done_seen", got_done, 1'b1);
        check_eq("done_cycle", done_n, want_n);
        check_eq("drive_order", bad_vec, 0);
        check_eq("busy_during", bad_busy, 0);
        check_eq("observed", observed, want_obs);
        check_eq("mismatch", mismatch, want_obs ^ exp_tt);
        check_eq("pass", pass, (abort_row < 0) && (want_obs == exp_tt));
        check_eq("aborted", aborted, abort_row >= 0);
        check_eq("done_in_busy", {in1, in2, in3, busy}, 4'b0000);
        @(negedge clk);
        check_eq("done_one_cycle", done, 1'b0);
        check_eq("results_hold", {observed, mismatch}, {want_obs, want_obs ^ exp_tt});
        $display("sweep model=%02h exp=%02h abort_row=%0d done@t0+%0d obs=%02h mis=%02h pass=%0b abt=%0b",
                 mdl, exp_tt, abort_row, done_n, observed, mismatch, pass, aborted);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; expected = 8'h00; model_tt = 8'h00;
        repeat (2) @(negedge clk);
        check_eq("reset_state",
                 {in1, in2, in3, busy, done, aborted, pass, observed, mismatch}, '0);
        reset = 1'b0;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
        check_eq("idle_abort_noop", {busy, done, aborted}, 3'b000);

        run_sweep(8'h95, 8'h95, -1, 1'b0, 1'b0, -1);
        run_sweep(8'h95, 8'h96, -1, 1'b0, 1'b0, -1);
        run_sweep(8'h95, 8'h95, 2, 1'b0, 1'b0, -1);
        run_sweep(8'h95, 8'h95, -1, 1'b1, 1'b0, -1);
        run_sweep(8'h95, 8'h95, -1, 1'b0, 1'b0, 17);
        run_sweep(8'h95, 8'h95, -1, 1'b0, 1'b0, -1);
        run_sweep(8'h3C, 8'h3C, -1, 1'b0, 1'b1, -1);
        run_sweep(8'hA7, 8'h00, 0, 1'b0, 1'b0, -1);
        run_sweep(8'hA7, 8'hA7, 7, 1'b0, 1'b0, -1);

        for (int k = 0; k < 12; k++) begin
            logic [7:0] m, e;
            int ar;
            m  = 8'($urandom);
            e  = ($urandom_range(0, 1) == 0) ? m : 8'($urandom);
            ar = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : -1;
            run_sweep(m, e, ar, $urandom_range(0, 3) == 0, 1'b0, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
